// File: rtl/bch_dec_stream.sv
// Streaming BCH(15,7) t=2 decoder over GF(16) (x^4+x+1): syndromes, closed-form
// error locator, CHIEN_PAR-wide sequential Chien search, saturating statistics.
module bch_dec_stream #(
  parameter int CHIEN_PAR = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_data,
  output logic [6:0]       out_msg,
  output logic [1:0]       out_nerr,
  output logic             out_uncorr,
  output logic [3:0]       out_s1,
  output logic [3:0]       out_s3,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  localparam int         NK     = 15 / CHIEN_PAR;
  localparam logic [3:0] K_LAST = 4'(NK - 1);

  typedef enum logic [1:0] {IDLE, SYND, CHIEN, OUT} state_t;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int n = 0; n < 4; n++) begin
      p = b[n] ? (p ^ t) : p;
      t = t[3] ? ({t[2:0], 1'b0} ^ 4'h3) : {t[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] alpha_pow(input logic [3:0] e);
    case (e)
      4'd0:  return 4'h1;
      4'd1:  return 4'h2;
      4'd2:  return 4'h4;
      4'd3:  return 4'h8;
      4'd4:  return 4'h3;
      4'd5:  return 4'h6;
      4'd6:  return 4'hC;
      4'd7:  return 4'hB;
      4'd8:  return 4'h5;
      4'd9:  return 4'hA;
      4'd10: return 4'h7;
      4'd11: return 4'hE;
      4'd12: return 4'hF;
      4'd13: return 4'hD;
      4'd14: return 4'h9;
      default: return 4'h1;
    endcase
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    case (a)
      4'h1: return 4'h1;
      4'h2: return 4'h9;
      4'h3: return 4'hE;
      4'h4: return 4'hD;
      4'h5: return 4'hB;
      4'h6: return 4'h7;
      4'h7: return 4'h6;
      4'h8: return 4'hF;
      4'h9: return 4'h2;
      4'hA: return 4'hC;
      4'hB: return 4'h5;
      4'hC: return 4'hA;
      4'hD: return 4'h4;
      4'hE: return 4'h3;
      4'hF: return 4'h8;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [14:0]      raw_q, raw_d, work_q, work_d;
  logic [3:0]       l1_q, l1_d, l2_q, l2_d, s1_q, s1_d, s3_q, s3_d;
  logic [1:0]       deg_q, deg_d;
  logic             bad_q, bad_d;
  logic [3:0]       roots_q, roots_d, k_q, k_d;
  logic             ov_q, ov_d, ou_q, ou_d;
  logic [14:0]      od_q, od_d;
  logic [1:0]       on_q, on_d;
  logic [3:0]       os1_q, os1_d, os3_q, os3_d;
  logic [CNT_W-1:0] cw_q, cw_d, cc_q, cc_d, cu_q, cu_d;
  logic [3:0]       syn1_s, syn3_s, cube_s;
  logic [14:0]      chien_word_s;
  logic [3:0]       chien_roots_s;
  logic             uncorr_s, hs_s;

  // Syndromes of the latched word: S1 = r(alpha), S3 = r(alpha^3).
  always_comb begin
    syn1_s = 4'h0;
    syn3_s = 4'h0;
    for (int i = 0; i < 15; i++) begin
      syn1_s = raw_q[i] ? (syn1_s ^ alpha_pow(4'(i))) : syn1_s;
      syn3_s = raw_q[i] ? (syn3_s ^ alpha_pow(4'((3 * i) % 15))) : syn3_s;
    end
    cube_s = gf_mul(gf_mul(syn1_s, syn1_s), syn1_s);
  end

  // Evaluate L(alpha^-i) for this cycle's slice of positions and flip the roots.
  always_comb begin : chien_eval
    logic [3:0] idx, e1, e2, ev;
    idx = 4'h0; e1 = 4'h0; e2 = 4'h0; ev = 4'h0;
    chien_word_s  = work_q;
    chien_roots_s = roots_q;
    for (int j = 0; j < CHIEN_PAR; j++) begin
      idx = 4'(int'(k_q) * CHIEN_PAR + j);
      e1  = 4'((15 - int'(idx)) % 15);
      e2  = 4'((2 * int'(e1)) % 15);
      ev  = 4'h1 ^ gf_mul(l1_q, alpha_pow(e1)) ^ gf_mul(l2_q, alpha_pow(e2));
      if (ev == 4'h0) begin
        chien_word_s[idx] = ~chien_word_s[idx];
        chien_roots_s     = chien_roots_s + 4'd1;
      end else begin
        chien_roots_s = chien_roots_s;
      end
    end
  end

  assign uncorr_s = bad_q | (roots_q != {2'b00, deg_q});
  assign hs_s     = ov_q & out_ready;

  // Decoder FSM next-state and datapath register loads.
  always_comb begin
    state_d = state_q; raw_d = raw_q; work_d = work_q;
    l1_d = l1_q; l2_d = l2_q; deg_d = deg_q; bad_d = bad_q;
    s1_d = s1_q; s3_d = s3_q; roots_d = roots_q; k_d = k_q;
    ov_d = ov_q; od_d = od_q; on_d = on_q; ou_d = ou_q; os1_d = os1_q; os3_d = os3_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          raw_d   = in_data;
          work_d  = in_data;
          state_d = SYND;
        end else begin
          state_d = IDLE;
        end
      end
      SYND: begin
        s1_d = syn1_s;
        s3_d = syn3_s;
        roots_d = 4'd0;
        k_d = 4'd0;
        state_d = CHIEN;
        // S1=0 leaves L(x)=1, so the fixed-latency search finds no roots.
        if (syn1_s == 4'h0) begin
          l1_d = 4'h0; l2_d = 4'h0; deg_d = 2'd0; bad_d = (syn3_s != 4'h0);
        end else if (syn3_s == cube_s) begin
          l1_d = syn1_s; l2_d = 4'h0; deg_d = 2'd1; bad_d = 1'b0;
        end else begin
          l1_d = syn1_s; l2_d = gf_mul(syn3_s ^ cube_s, gf_inv(syn1_s));
          deg_d = 2'd2; bad_d = 1'b0;
        end
      end
      CHIEN: begin
        work_d  = chien_word_s;
        roots_d = chien_roots_s;
        if (k_q == K_LAST) begin
          state_d = OUT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      OUT: begin
        if (!ov_q) begin
          ov_d  = 1'b1;
          ou_d  = uncorr_s;
          od_d  = uncorr_s ? raw_q : work_q;
          on_d  = uncorr_s ? 2'd0 : roots_q[1:0];
          os1_d = s1_q;
          os3_d = s3_q;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end else begin
          ov_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics counters: clear wins over a same-cycle handshake.
  always_comb begin
    cw_d = cw_q; cc_d = cc_q; cu_d = cu_q;
    if (stat_clr) begin
      cw_d = '0; cc_d = '0; cu_d = '0;
    end else if (hs_s) begin
      cw_d = sat_inc(cw_q);
      if (ou_q) begin
        cu_d = sat_inc(cu_q);
      end else if (on_q != 2'd0) begin
        cc_d = sat_inc(cc_q);
      end else begin
        cc_d = cc_q;
      end
    end else begin
      cw_d = cw_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE; raw_q <= 15'h0; work_q <= 15'h0;
      l1_q <= 4'h0; l2_q <= 4'h0; deg_q <= 2'd0; bad_q <= 1'b0;
      s1_q <= 4'h0; s3_q <= 4'h0; roots_q <= 4'd0; k_q <= 4'd0;
      ov_q <= 1'b0; od_q <= 15'h0; on_q <= 2'd0; ou_q <= 1'b0;
      os1_q <= 4'h0; os3_q <= 4'h0;
      cw_q <= '0; cc_q <= '0; cu_q <= '0;
    end else begin
      state_q <= state_d; raw_q <= raw_d; work_q <= work_d;
      l1_q <= l1_d; l2_q <= l2_d; deg_q <= deg_d; bad_q <= bad_d;
      s1_q <= s1_d; s3_q <= s3_d; roots_q <= roots_d; k_q <= k_d;
      ov_q <= ov_d; od_q <= od_d; on_q <= on_d; ou_q <= ou_d;
      os1_q <= os1_d; os3_q <= os3_d;
      cw_q <= cw_d; cc_q <= cc_d; cu_q <= cu_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign out_msg    = od_q[14:8];
  assign out_nerr   = on_q;
  assign out_uncorr = ou_q;
  assign out_s1     = os1_q;
  assign out_s3     = os3_q;
  assign cnt_words  = cw_q;
  assign cnt_corr   = cc_q;
  assign cnt_uncorr = cu_q;

endmodule
